led_alarm_pattern: RTL and testbench

Parametrised LED alarm annunciator: on an alarm trigger it takes ownership of an N-wide LED bank and animates one of four selectable patterns at a divided step rate until it times out, is dismissed, or is snoozed. It replaces the fixed 8-LED rotate-only alarm display in the clock top level and drives the same LED output multiplexer. All stepping uses an internal clock-enable, with no derived clocks.

---
 rtl/led_alarm_pkg.sv | 20 ++
 rtl/led_alarm_pattern_tick_gen.sv | 37 +++
 rtl/led_alarm_pattern.sv | 174 +++++++++++++++++
 tb/tb_led_alarm_pattern.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_alarm_pkg.sv
// Shared types for the LED alarm annunciator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package led_alarm_pkg;

    // Pattern select, latched when the alarm starts ringing.
    typedef enum logic [1:0] {
        ROTATE = 2'd0,
        BOUNCE = 2'd1,
        BLINK  = 2'd2,
        FILL   = 2'd3
    } alarm_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/led_alarm_pattern_tick_gen.sv
// Clock-enable divider: one-cycle tick every DIV enabled clk cycles.
// Latency: tick asserted while count == DIV-1; count restarts at 0 after clear.
// Backpressure: none; en freezes the count, clear forces it to 0 (clear wins).
//
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : synchronous clear of the count
//   en         : count enable
//   tick       : pulse on the last cycle of each DIV-cycle period
module tick_gen #(
    parameter int DIV = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/led_alarm_pattern.sv
// LED alarm annunciator: owns the LED bank while ringing and animates a pattern.
// Latency: outputs change one clk after the sampling edge of alarm/dismiss/snooze.
// Backpressure: none; control inputs are sampled every cycle, priority dismiss > snooze > alarm > timeout.
//
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   alarm      : trigger (level or pulse); while ringing it restarts the duration
//   dismiss    : stop and return to idle
//   snooze     : park in SNOOZE for SNOOZE_STEPS steps (limited to MAX_SNOOZES per event)
//   mode       : pattern select, latched on entry from idle
//   led_mux    : high while ringing (LED bank owned by this block)
//   busy       : high while ringing or snoozing
//   leds       : pattern output, zero unless ringing
module led_alarm_pattern
    import led_alarm_pkg::*;
#(
    parameter int N_LEDS         = 8,
    parameter int TICK_DIV       = 10_000_000,
    parameter int DURATION_STEPS = 64,
    parameter int SNOOZE_STEPS   = 300,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alarm,
    input  logic              dismiss,
    input  logic              snooze,
    input  alarm_mode_t       mode,
    output logic              led_mux,
    output logic              busy,
    output logic [N_LEDS-1:0] leds
);

    // One step counter serves both RING (duration) and SNOOZE, so it is sized
    // for the larger of the two limits.
    localparam int STEP_MAX = (DURATION_STEPS > SNOOZE_STEPS) ? DURATION_STEPS : SNOOZE_STEPS;
    localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
    // The snooze counter must be able to hold MAX_SNOOZES itself.
    localparam int SNZ_W    = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;

    localparam logic [STEP_W-1:0] DUR_LAST  = STEP_W'(DURATION_STEPS - 1);
    localparam logic [STEP_W-1:0] SNZ_LAST  = STEP_W'(SNOOZE_STEPS - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LIMIT = SNZ_W'(MAX_SNOOZES);

    alarm_state_t      state;
    alarm_mode_t       mode_q;
    logic [N_LEDS-1:0] pattern;
    logic              dir_up;      // BOUNCE direction, 1 = towards MSB
    logic [STEP_W-1:0] step_cnt;
    logic [SNZ_W-1:0]  snz_used;

    logic              tick;
    logic              div_clear;
    logic              snz_ok;
    logic [N_LEDS-1:0] pat_step;
    logic              dir_step;

    function automatic logic [N_LEDS-1:0] init_pattern(input alarm_mode_t m);
        return (m == BLINK) ? {N_LEDS{1'b1}} : N_LEDS'(1);
    endfunction

    // Next pattern value, applied only on a tick while ringing.
    always_comb begin
        pat_step = pattern;
        dir_step = dir_up;
        case (mode_q)
            ROTATE: pat_step = {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
            BOUNCE: begin
                // Reverse at the ends so each end position is shown once per pass.
                if (dir_up) begin
                    if (pattern[N_LEDS-1]) begin
                        pat_step = pattern >> 1;
                        dir_step = 1'b0;
                    end else begin
                        pat_step = pattern << 1;
                    end
                end else begin
                    if (pattern[0]) begin
                        pat_step = pattern << 1;
                        dir_step = 1'b1;
                    end else begin
                        pat_step = pattern >> 1;
                    end
                end
            end
            BLINK:  pat_step = ~pattern;
            FILL:   pat_step = (&pattern) ? N_LEDS'(1) : {pattern[N_LEDS-2:0], 1'b1};
            default: pat_step = pattern;
        endcase
    end

    assign snz_ok = (snz_used < SNZ_LIMIT);

    // The divider restarts on every transition that begins a fresh step period
    // and is held at 0 while idle. Timed transitions land on a natural wrap.
    assign div_clear = (state == IDLE) || dismiss
                    || ((state == RING)   && snooze && snz_ok)
                    || ((state == SNOOZE) && alarm);

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear),
        .en    (state != IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mode_q   <= ROTATE;
            pattern  <= '0;
            dir_up   <= 1'b1;
            step_cnt <= '0;
            snz_used <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (alarm && !dismiss) begin
                        state    <= RING;
                        mode_q   <= mode;
                        pattern  <= init_pattern(mode);
                        dir_up   <= 1'b1;
                        step_cnt <= '0;
                        snz_used <= '0;
                    end
                end
                RING: begin
                    if (dismiss) begin
                        state <= IDLE;
                    end else if (snooze && snz_ok) begin
                        state    <= SNOOZE;
                        snz_used <= snz_used + 1'b1;
                        step_cnt <= '0;
                    end else begin
                        // A retrigger restarts the duration but not the animation.
                        if (tick) begin
                            pattern <= pat_step;
                            dir_up  <= dir_step;
                        end
                        if (alarm) begin
                            step_cnt <= '0;
                        end else if (tick && (step_cnt == DUR_LAST)) begin
                            state    <= IDLE;
                            step_cnt <= '0;
                        end else if (tick) begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end
                SNOOZE: begin
                    if (dismiss) begin
                        state <= IDLE;
                    end else if (alarm || (tick && (step_cnt == SNZ_LAST))) begin
                        state    <= RING;
                        pattern  <= init_pattern(mode_q);
                        dir_up   <= 1'b1;
                        step_cnt <= '0;
                    end else if (tick) begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign led_mux = (state == RING);
    assign busy    = (state != IDLE);
    assign leds    = led_mux ? pattern : '0;

endmodule

// File: tb/tb_led_alarm_pattern.sv
// Directed self-checking bench for led_alarm_pattern (N_LEDS=4, TICK_DIV=4,
// DURATION_STEPS=6, SNOOZE_STEPS=3, MAX_SNOOZES=1).
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_led_alarm_pattern;
    import led_alarm_pkg::*;

    logic        clk;
    logic        reset;
    logic        alarm;
    logic        dismiss;
    logic        snooze;
    alarm_mode_t mode;
    logic        led_mux;
    logic        busy;
    logic [3:0]  leds;

    int checks = 0;
    int errors = 0;

    led_alarm_pattern #(
        .N_LEDS         (4),
        .TICK_DIV       (4),
        .DURATION_STEPS (6),
        .SNOOZE_STEPS   (3),
        .MAX_SNOOZES    (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .alarm   (alarm),
        .dismiss (dismiss),
        .snooze  (snooze),
        .mode    (mode),
        .led_mux (led_mux),
        .busy    (busy),
        .leds    (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start an alarm in mode m, check cnt pattern steps (packed LSB-first, 4 bits
    // each) at 4-cycle spacing, then dismiss.
    task automatic run_seq(input string name, input alarm_mode_t m,
                           input logic [27:0] seq, input int cnt);
        mode  = m;
        alarm = 1'b1;
        cyc(1);
        alarm = 1'b0;
        mode  = ROTATE;     // must not affect the latched mode
        for (int i = 0; i < cnt; i++) begin
            if (i > 0) cyc(4);
            chk($sformatf("%s_step%0d", name, i), leds, seq[4*i +: 4]);
        end
        dismiss = 1'b1;
        cyc(1);
        dismiss = 1'b0;
        chk({name, "_dismiss_busy"}, busy, 0);
    endtask

    initial begin
        reset   = 1'b1;
        alarm   = 1'b0;
        dismiss = 1'b0;
        snooze  = 1'b0;
        mode    = ROTATE;
        cyc(2);
        chk("rst_leds", leds, 0);
        chk("rst_mux", led_mux, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        cyc(2);

        // ROTATE, plain timeout, mode change while ringing ignored.
        mode  = ROTATE;
        alarm = 1'b1;
        cyc(1);
        alarm = 1'b0;
        mode  = FILL;
        chk("rot_s0", leds, 4'b0001);
        chk("rot_mux", led_mux, 1);
        chk("rot_busy", busy, 1);
        cyc(4); chk("rot_s1", leds, 4'b0010);
        cyc(4); chk("rot_s2", leds, 4'b0100);
        cyc(4); chk("rot_s3", leds, 4'b1000);
        cyc(4); chk("rot_s4", leds, 4'b0001);
        cyc(7); chk("rot_pre_to_mux", led_mux, 1);
        chk("rot_pre_to_leds", leds, 4'b0010);
        cyc(1); chk("rot_to_leds", leds, 0);
        chk("rot_to_mux", led_mux, 0);
        chk("rot_to_busy", busy, 0);

        // BOUNCE with retrigger on step 5.
        mode  = BOUNCE;
        alarm = 1'b1;
        cyc(1);
        alarm = 1'b0;
        chk("bnc_s0", leds, 4'b0001);
        cyc(4); chk("bnc_s1", leds, 4'b0010);
        cyc(4); chk("bnc_s2", leds, 4'b0100);
        cyc(4); chk("bnc_s3", leds, 4'b1000);
        cyc(4); chk("bnc_s4", leds, 4'b0100);
        cyc(4); chk("bnc_s5", leds, 4'b0010);
        alarm = 1'b1;
        cyc(1);
        alarm = 1'b0;
        chk("bnc_retrig_leds", leds, 4'b0010);
        cyc(3); chk("bnc_s6", leds, 4'b0001);
        chk("bnc_s6_mux", led_mux, 1);
        cyc(4); chk("bnc_s7", leds, 4'b0010);
        cyc(15); chk("bnc_pre_to_mux", led_mux, 1);
        chk("bnc_pre_to_leds", leds, 4'b0100);
        cyc(1); chk("bnc_to_mux", led_mux, 0);
        chk("bnc_to_leds", leds, 0);

        run_seq("fill", FILL, {8'h0, 4'b0001, 4'b1111, 4'b0111, 4'b0011, 4'b0001}, 5);
        run_seq("blink", BLINK, {16'h0, 4'b1111, 4'b0000, 4'b1111}, 3);

        // Snooze, re-ring, second snooze ignored, timeout.
        mode  = ROTATE;
        alarm = 1'b1;
        cyc(1);
        alarm = 1'b0;
        cyc(4); chk("snz_pre", leds, 4'b0010);
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        chk("snz_leds", leds, 0);
        chk("snz_busy", busy, 1);
        chk("snz_mux", led_mux, 0);
        cyc(11); chk("snz_end_leds", leds, 0);
        chk("snz_end_busy", busy, 1);
        cyc(1); chk("snz_rering", leds, 4'b0001);
        chk("snz_rering_mux", led_mux, 1);
        cyc(1);
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        chk("snz2_ignored_mux", led_mux, 1);
        chk("snz2_ignored_leds", leds, 4'b0001);
        cyc(2); chk("snz2_s1", leds, 4'b0010);
        cyc(19); chk("snz2_pre_to_leds", leds, 4'b0010);
        cyc(1); chk("snz2_to_busy", busy, 0);
        chk("snz2_to_leds", leds, 0);

        // New event: snooze allowed again, alarm during SNOOZE re-rings at once.
        alarm = 1'b1;
        cyc(1);
        alarm = 1'b0;
        cyc(4);
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        chk("snz3_mux", led_mux, 0);
        chk("snz3_busy", busy, 1);
        cyc(3);
        alarm = 1'b1;
        cyc(1);
        alarm = 1'b0;
        chk("snz3_alarm_leds", leds, 4'b0001);
        chk("snz3_alarm_mux", led_mux, 1);
        cyc(4); chk("snz3_alarm_s1", leds, 4'b0010);
        dismiss = 1'b1;
        cyc(1);
        dismiss = 1'b0;
        chk("snz3_dismiss_busy", busy, 0);

        // dismiss and alarm together, in IDLE and in RING.
        alarm   = 1'b1;
        dismiss = 1'b1;
        cyc(1);
        alarm   = 1'b0;
        dismiss = 1'b0;
        chk("dis_idle_busy", busy, 0);
        chk("dis_idle_leds", leds, 0);
        alarm = 1'b1;
        cyc(1);
        alarm = 1'b0;
        chk("dis_ring_pre", led_mux, 1);
        cyc(2);
        alarm   = 1'b1;
        dismiss = 1'b1;
        cyc(1);
        alarm   = 1'b0;
        dismiss = 1'b0;
        chk("dis_ring_busy", busy, 0);
        chk("dis_ring_leds", leds, 0);
        cyc(1); chk("dis_ring_stay", busy, 0);

        // Asynchronous reset mid-RING.
        alarm = 1'b1;
        cyc(1);
        alarm = 1'b0;
        cyc(6);
        chk("arst_pre_mux", led_mux, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_leds", leds, 0);
        chk("arst_mux", led_mux, 0);
        chk("arst_busy", busy, 0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        alarm = 1'b1;
        cyc(1);
        alarm = 1'b0;
        chk("post_rst_s0", leds, 4'b0001);
        cyc(4); chk("post_rst_s1", leds, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
